// File: rtl/mux2x32_pkg.sv
// ============================================================================
// mux2x32_pkg : shared datapath word type and defaults for the 2:1 selector
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mux2x32_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef logic [WIDTH_DEF-1:0] word_t;

    localparam word_t RST_VAL_DEF = '0;

endpackage

`default_nettype wire

// File: rtl/mux2x32_core.sv
// ============================================================================
// mux2x32_core : purely combinational 2:1 word select (s=0 -> a0, s=1 -> a1)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mux2x32_core
    import mux2x32_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // The conditional operator merges a0/a1 bitwise when s is X, so an
    // unknown select shows up as X on every differing bit.
    assign y = s ? a1 : a0;

endmodule

`default_nettype wire

// File: rtl/mux2x32_sel.sv
// ============================================================================
// mux2x32_sel : 2:1 word selector with combinational y and enabled register y_q
//               (MUX2X32_SEL_PARITY_EN adds par_q, parity of the loaded word)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux2x32_sel
    import mux2x32_pkg::*;
#(
    parameter int unsigned      WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
`ifdef MUX2X32_SEL_PARITY_EN
    ,
    output logic             par_q
`endif
);

    mux2x32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a0 (a0),
        .a1 (a1),
        .s  (s),
        .y  (y)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            y_q <= RST_VAL;
        end else if (en) begin
            y_q <= y;
        end
    end

`ifdef MUX2X32_SEL_PARITY_EN
    // Parity is taken from the same word that y_q captures, so both move together.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            par_q <= ^RST_VAL;
        end else if (en) begin
            par_q <= ^y;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2x32_sel.sv
// ============================================================================
// tb_mux2x32_sel : directed self-checking bench for mux2x32_sel
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mux2x32_sel;

    logic        clk;
    logic        clrn;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        s;
    logic        en;
    logic [31:0] y;
    logic [31:0] y_q;
`ifdef MUX2X32_SEL_PARITY_EN
    logic        par_q;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    mux2x32_sel dut (
        .clk  (clk),
        .clrn (clrn),
        .a0   (a0),
        .a1   (a1),
        .s    (s),
        .en   (en),
        .y    (y),
        .y_q  (y_q)
`ifdef MUX2X32_SEL_PARITY_EN
        ,
        .par_q(par_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b0;
        en   = 1'b0;
        s    = 1'b0;
        a0   = 32'h0000F0F0;
        a1   = 32'hFFFFF0F0;

        // Reset state and zero-select extender case
        #1;
        push("reset_yq", 32'h0000_0000);
        pop_check(y_q);
`ifdef MUX2X32_SEL_PARITY_EN
        push("reset_par", 32'h0);
        pop_check({31'b0, par_q});
`endif
        push("ext_zero_y", 32'h0000F0F0);
        pop_check(y);
        #20;
        s = 1'b1;
        #1;
        push("ext_sign_y", 32'hFFFFF0F0);
        pop_check(y);

        // Release reset between edges; nothing should change until a clock
        @(negedge clk);
        clrn = 1'b1;
        #1;
        push("release_hold", 32'h0000_0000);
        pop_check(y_q);

        // Registered load
        @(negedge clk);
        a0 = 32'h12345678;
        s  = 1'b0;
        en = 1'b1;
        push("load_yq", 32'h12345678);
        tick();
        pop_check(y_q);

        // Hold with en=0 across three edges
        @(negedge clk);
        a1 = 32'hDEADBEEF;
        s  = 1'b1;
        en = 1'b0;
        repeat (3) tick();
        push("hold_yq", 32'h12345678);
        pop_check(y_q);
        push("hold_y", 32'hDEADBEEF);
        pop_check(y);

        // Load DEADBEEF then assert reset mid-cycle
        @(negedge clk);
        en = 1'b1;
        push("load_dead", 32'hDEADBEEF);
        tick();
        pop_check(y_q);
        #2;
        clrn = 1'b0;
        #1;
        push("async_rst_yq", 32'h0000_0000);
        pop_check(y_q);
        push("rst_y_follow", 32'hDEADBEEF);
        pop_check(y);
        a0 = 32'hCAFEF00D;
        s  = 1'b0;
        #1;
        push("rst_y_sel0", 32'hCAFEF00D);
        pop_check(y);
        tick();
        push("rst_held_edge", 32'h0000_0000);
        pop_check(y_q);
        @(negedge clk);
        clrn = 1'b1;
        push("post_rst_load", 32'hCAFEF00D);
        tick();
        pop_check(y_q);

        // Boundary words, s toggled every cycle; y_q trails y by one edge
        @(negedge clk);
        a0 = 32'h0000_0000;
        a1 = 32'hFFFF_FFFF;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = i[0];
            #1;
            push("bnd_y", i[0] ? 32'hFFFF_FFFF : 32'h0000_0000);
            pop_check(y);
            push("bnd_yq", i[0] ? 32'hFFFF_FFFF : 32'h0000_0000);
            tick();
            pop_check(y_q);
            @(negedge clk);
        end

        // Equal inputs: output independent of s
        a0 = 32'hA5A5A5A5;
        a1 = 32'hA5A5A5A5;
        for (int i = 0; i < 4; i++) begin
            s = i[0];
            #1;
            push("eq_y", 32'hA5A5A5A5);
            pop_check(y);
            tick();
            push("eq_yq", 32'hA5A5A5A5);
            pop_check(y_q);
            @(negedge clk);
        end

`ifdef MUX2X32_SEL_PARITY_EN
        // Parity of loaded word
        a0 = 32'h0000_0001;
        s  = 1'b0;
        tick();
        push("par_one", 32'h1);
        pop_check({31'b0, par_q});
        @(negedge clk);
        a0 = 32'h0000_0003;
        tick();
        push("par_three", 32'h0);
        pop_check({31'b0, par_q});
        @(negedge clk);
        a0 = 32'h0000_0001;
        tick();
        #2;
        clrn = 1'b0;
        #1;
        push("par_reset", 32'h0);
        pop_check({31'b0, par_q});
        clrn = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
